// File: rtl/cd_llc_port_arbiter.sv
// Per-LLC-port scheduler: packet-granular round-robin over N_REQ request links,
// holding each grant for BURST flits and gating new packets on an LLC credit pool.
module cd_llc_port_arbiter #(
    parameter int N_REQ   = 8,
    parameter int BURST   = 2,
    parameter int MAX_OUT = 2,
    parameter int IDX_W   = $clog2(N_REQ),
    localparam int CRED_W = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_v,
    input  logic              llc_ro,
    input  logic              rsp_done,
    output logic [N_REQ-1:0]  gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              llc_so,
    output logic              fire,
    output logic [CRED_W-1:0] credits,
    output logic              busy,
    output logic              err_ovf
);

    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [CRED_W-1:0]  credits_q, credits_d;
    logic               err_ovf_q, err_ovf_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;
    logic               take_credit;
    logic               last_beat;

    // Round-robin search starting just after the last link served, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_REQ)) begin
                cand = cand - (IDX_W + 1)'(N_REQ);
            end
            if (!pick_found && req_v[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Outputs depend only on registered state and the current req_v/llc_ro,
    // so llc_ro never reaches gnt combinationally.
    assign busy        = (state_q == XFER);
    assign llc_so      = busy & req_v[gnt_idx_q];
    assign fire        = llc_so & llc_ro;
    assign gnt         = busy ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_q) : '0;
    assign gnt_idx     = gnt_idx_q;
    assign credits     = credits_q;
    assign err_ovf     = err_ovf_q;
    assign take_credit = fire && (beat_q == '0);
    assign last_beat   = fire && (beat_q == BEAT_W'(BURST - 1));

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        beat_d    = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_found && (credits_q != '0)) begin
                    state_d   = XFER;
                    gnt_idx_d = pick_idx;
                    beat_d    = '0;
                end
            end
            XFER: begin
                if (last_beat) begin
                    state_d   = IDLE;
                    rr_ptr_d  = gnt_idx_q;
                    gnt_idx_d = '0;
                    beat_d    = '0;
                end else if (fire) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_idx_d = '0;
                beat_d    = '0;
            end
        endcase
    end

    // A first fire and a returning reply in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        err_ovf_d = err_ovf_q;
        if (rsp_done && !take_credit) begin
            if (credits_q == CRED_W'(MAX_OUT)) begin
                err_ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + CRED_W'(1);
            end
        end else if (take_credit && !rsp_done) begin
            credits_d = credits_q - CRED_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IDX_W'(N_REQ - 1);
            beat_q    <= '0;
            credits_q <= CRED_W'(MAX_OUT);
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            beat_q    <= beat_d;
            credits_q <= credits_d;
            err_ovf_q <= err_ovf_d;
        end
    end

endmodule

// File: tb/tb_cd_llc_port_arbiter.sv
// Bench for cd_llc_port_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a packet-level reference model.
module tb_cd_llc_port_arbiter;

    localparam int N_REQ   = 8;
    localparam int BURST   = 2;
    localparam int MAX_OUT = 2;
    localparam int IDX_W   = 3;
    localparam int CRED_W  = $clog2(MAX_OUT + 1);

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]  req_v = '0;
    logic              llc_ro = 1'b0;
    logic              rsp_done = 1'b0;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              llc_so;
    logic              fire;
    logic [CRED_W-1:0] credits;
    logic              busy;
    logic              err_ovf;

    cd_llc_port_arbiter #(
        .N_REQ(N_REQ), .BURST(BURST), .MAX_OUT(MAX_OUT), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .req_v(req_v), .llc_ro(llc_ro),
        .rsp_done(rsp_done), .gnt(gnt), .gnt_idx(gnt_idx), .llc_so(llc_so),
        .fire(fire), .credits(credits), .busy(busy), .err_ovf(err_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port (-1 = nobody), flits sent, last served.
    int m_owner, m_sent, m_last, m_credits;
    bit m_err;

    // Grant-order scoreboard
    logic [IDX_W-1:0] exp_q[$];
    bit sb_on = 1'b0;
    bit seen_busy = 1'b0;
    int fire_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_sent    = 0;
        m_last    = N_REQ - 1;
        m_credits = MAX_OUT;
        m_err     = 1'b0;
        seen_busy = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N_REQ-1:0] e_gnt;
        bit e_so;
        e_gnt = '0;
        e_so  = 1'b0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_so = req_v[m_owner];
        end
        check("gnt",     32'(gnt),     32'(e_gnt));
        check("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? m_owner : 0);
        check("llc_so",  32'(llc_so),  32'(e_so));
        check("fire",    32'(fire),    32'(e_so && llc_ro));
        check("credits", 32'(credits), m_credits);
        check("busy",    32'(busy),    32'(m_owner >= 0));
        check("err_ovf", 32'(err_ovf), 32'(m_err));
    endtask

    task automatic model_step(input logic [N_REQ-1:0] r, input logic ro, input logic rsp);
        bit f;
        bit take;
        int old_cred;
        int p;
        f        = (m_owner >= 0) && r[m_owner] && ro;
        take     = f && (m_sent == 0);
        old_cred = m_credits;
        if (rsp && !take) begin
            if (m_credits == MAX_OUT) m_err = 1'b1;
            else m_credits++;
        end else if (take && !rsp) begin
            m_credits--;
        end
        if (m_owner < 0) begin
            if (old_cred > 0) begin
                p = rr_pick(r, m_last);
                if (p >= 0) begin
                    m_owner = p;
                    m_sent  = 0;
                end
            end
        end else if (f) begin
            m_sent++;
            if (m_sent == BURST) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    // driver: apply inputs on negedge, check mid-cycle, advance model at posedge
    task automatic run_cycle(input logic [N_REQ-1:0] r, input logic ro, input logic rsp);
        @(negedge clk);
        req_v    = r;
        llc_ro   = ro;
        rsp_done = rsp;
        #1;
        check_outputs();
        if (fire) fire_cnt++;
        if (sb_on && busy && !seen_busy) begin
            if (exp_q.size() == 0) check("sb_extra_grant", 32'(gnt_idx), 32'hFFFF_FFFF);
            else check("sb_grant_order", 32'(gnt_idx), 32'(exp_q.pop_front()));
        end
        seen_busy = busy;
        @(posedge clk);
        model_step(r, ro, rsp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        req_v    = '0;
        llc_ro   = 1'b0;
        rsp_done = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0] r;
        logic ro, rsp;

        // single link, one packet
        do_reset();
        run_cycle(8'h01, 1'b1, 1'b0);
        run_cycle(8'h01, 1'b1, 1'b0);
        run_cycle(8'h01, 1'b1, 1'b0);
        #1 check("t1_credits", 32'(credits), 1);
        run_cycle(8'h00, 1'b1, 1'b0);
        #1 check("t1_gnt_drop", 32'(gnt), 0);

        // all links, replies returned -> strict rotation
        do_reset();
        for (int i = 0; i < N_REQ; i++) exp_q.push_back(IDX_W'(i));
        exp_q.push_back(IDX_W'(0));
        sb_on = 1'b1;
        for (int c = 0; c < 28; c++) begin
            rsp = (m_owner < 0) && (m_credits < MAX_OUT);
            run_cycle(8'hFF, 1'b1, rsp);
        end
        sb_on = 1'b0;
        check("t2_all_granted", exp_q.size(), 0);

        // credit exhaustion and recovery
        do_reset();
        for (int c = 0; c < 6; c++) run_cycle(8'h05, 1'b1, 1'b0);
        #1 check("t3_credits_zero", 32'(credits), 0);
        for (int c = 0; c < 3; c++) run_cycle(8'h01, 1'b1, 1'b0);
        #1 check("t3_no_grant", 32'(busy), 0);
        run_cycle(8'h01, 1'b1, 1'b1);
        run_cycle(8'h01, 1'b1, 1'b0);
        run_cycle(8'h01, 1'b1, 1'b0);
        #1 check("t3_regrant", 32'(gnt), 32'h01);

        // mid-packet stalls
        do_reset();
        fire_cnt = 0;
        run_cycle(8'h01, 1'b1, 1'b0);
        run_cycle(8'h01, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) run_cycle(8'h01, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) run_cycle(8'h00, 1'b1, 1'b0);
        #1 check("t4_gnt_held", 32'(gnt), 32'h01);
        run_cycle(8'h01, 1'b1, 1'b0);
        check("t4_fire_count", fire_cnt, BURST);

        // reply coinciding with first fire, then overflow
        run_cycle(8'h01, 1'b1, 1'b0);
        run_cycle(8'h01, 1'b1, 1'b1);
        #1 check("t5_cred_unchanged", 32'(credits), 1);
        run_cycle(8'h01, 1'b1, 1'b0);
        run_cycle(8'h00, 1'b1, 1'b1);
        run_cycle(8'h00, 1'b1, 1'b1);
        #1 check("t5_err_set", 32'(err_ovf), 1);
        for (int c = 0; c < 3; c++) run_cycle(8'h00, 1'b1, 1'b0);
        #1 check("t5_err_sticky", 32'(err_ovf), 1);

        // asynchronous reset in the middle of a packet
        do_reset();
        run_cycle(8'hFF, 1'b1, 1'b0);
        run_cycle(8'hFF, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_gnt",     32'(gnt),     0);
        check("arst_llc_so",  32'(llc_so),  0);
        check("arst_busy",    32'(busy),    0);
        check("arst_credits", 32'(credits), MAX_OUT);
        model_reset();
        req_v    = '0;
        llc_ro   = 1'b0;
        rsp_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(IDX_W'(0));
        sb_on = 1'b1;
        run_cycle(8'hFF, 1'b1, 1'b0);
        run_cycle(8'hFF, 1'b1, 1'b0);
        sb_on = 1'b0;
        check("arst_first_grant", exp_q.size(), 0);

        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r   = ($urandom_range(0, 5) == 0) ? '0 : N_REQ'($urandom & $urandom);
            ro  = ($urandom_range(0, 3) != 0);
            rsp = ($urandom_range(0, 3) == 0);
            run_cycle(r, ro, rsp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
